cache_mem_responder: RTL and testbench
======================================

// Module: cache_mem_responder
// PURPOSE
//   Memory-side responder for the cache's line-fill/write-back memory port (mwrite_en/maddr/mdata/mout).
//   Models imem/dmem as word-addressed RAM with configurable access latency.
//   Adds a req/valid handshake so cache miss handling can be exercised against slow memory.
//   Sits between the cache controller's memory port and the backing store; one request in flight.
// PARAMETERS
//   ADDR_WIDTH  10  word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits
//   LATENCY     2   clock edges from request accept to response; legal range 1..15
// PORTS
//   clk        in   1   clock; all state updates on rising edge
//   reset      in   1   synchronous, active-high reset
//   mreq       in   1   initiator requests an access; held until mvalid
//   mwrite_en  in   1   1 = write mdata to maddr, 0 = read maddr; sampled at accept
//   maddr      in   32  byte address; sampled at accept
//   mdata      in   32  write data; sampled at accept
//   mbusy      out  1   1 while a request is in flight (state != IDLE)
//   mvalid     out  1   one-cycle response strobe; read data / write ack
//   mout       out  32  read data (read) or echo of written data (write); valid while mvalid=1
//   rd_count   out  32  number of completed reads
//   wr_count   out  32  number of completed writes
// BEHAVIOUR
//   Reset: state=IDLE; mbusy=0, mvalid=0, mout=0, rd_count=0, wr_count=0. RAM contents are not cleared.
//   Address map:
//   - word index = maddr[ADDR_WIDTH+1:2]; maddr[1:0] ignored.
//   - Bits above ADDR_WIDTH+1 are ignored, so addresses alias.
//   FSM states IDLE, WAIT, RESP; the counter cnt is 4 bits wide.
//   - IDLE & mreq: accept the request.
//     - Latch op, index and data.
//     - If LATENCY==1, go to RESP; otherwise go to WAIT with cnt=LATENCY-2.
//   - IDLE & !mreq: stay in IDLE.
//   - WAIT: if cnt==0, go to RESP; otherwise decrement cnt.
//   - RESP: mvalid=1 for exactly this cycle, then go to IDLE unconditionally.
//   On the edge entering RESP:
//   - read: mout <= RAM[idx].
//   - write: RAM[idx] <= data and mout <= data.
//   - A read accepted after a write therefore observes that write.
//   On the edge leaving RESP:
//   - rd_count or wr_count increments by 1, wrapping modulo 2**32.
//   - mout holds its value until the next response.
//   Latency: accept at edge k gives mvalid=1 in the cycle after edge k+LATENCY-1.
//   - Edge k+LATENCY is the edge that leaves RESP.
//   mbusy=1 in WAIT and RESP. mreq is ignored outside IDLE, and input changes mid-flight have no effect.
//   Back-to-back:
//   - If mreq is still high in the cycle after RESP, it is a new request.
//   - Consecutive accepts are spaced LATENCY+1 cycles apart.
//   - The initiator drops mreq in the cycle mvalid=1 if it has no further request.
//   Reset mid-operation: the in-flight request is discarded. A pending write is not committed and no count increments.
//   Reset has priority over mreq in the same cycle.
// TESTING
//   1. Reset, LATENCY=2: mbusy=0, mvalid=0, mout=0, counts=0; mreq=0 for 5 cycles -> outputs unchanged.
//   2. Write 0xDEADBEEF to 0x40, then read 0x40:
//      - mvalid is asserted 2 cycles after each accept.
//      - The read returns mout=0xDEADBEEF.
//      - Finally wr_count=1 and rd_count=1.
//   3. Alias/byte offset, ADDR_WIDTH=10: write 0x11 to 0x1004, then read 0x0006 -> mout=0x11.
//   4. Hold mreq=1 with alternating reads for 12 cycles, LATENCY=2 -> exactly 4 mvalid pulses, each 1 cycle, 3 cycles apart.
//   5. Write 0x55 to 0x8, then assert reset in the WAIT cycle. Next, read 0x8 -> mout equals the prior RAM value, not 0x55, and wr_count=0.
//   6. LATENCY=1: read accepted at edge k -> mvalid=1 in the cycle after edge k, and mbusy=0 after edge k+1.

Source files
------------

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache line-fill / write-back port.
// Word-addressed 32-bit RAM behind a req/valid handshake with a fixed,
// parameterisable access latency and a single request in flight.
//
// Handshake: the initiator raises mreq and holds it until mvalid. A request
// is accepted on a rising edge where the responder is idle and mreq=1.
// Opcode, address and data are sampled on that edge, and later input changes
// are ignored. mvalid is a one-cycle strobe. If mreq is still high in the
// cycle after mvalid, that is a new request.
module cache_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mreq,
  input  logic        mwrite_en,
  input  logic [31:0] maddr,
  input  logic [31:0] mdata,
  output logic        mbusy,
  output logic        mvalid,
  output logic [31:0] mout,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // WAIT is skipped entirely when LATENCY==1, so the preload is only
  // meaningful for LATENCY >= 2.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    op_we_q, op_we_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             data_q, data_d;
  logic [31:0]             mout_q, mout_d;
  logic [31:0]             rd_count_q, rd_count_d;
  logic [31:0]             wr_count_q, wr_count_d;

  logic [31:0]             mem_q [0:DEPTH-1];

  logic                    resp_go;
  logic                    acc_we;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_data;
  logic                    ram_we;

  // Byte offset and high address bits play no part in addressing.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{maddr[31:ADDR_WIDTH+2], maddr[1:0]};

  // Next-state, latch capture, RAM access on entry to RESP, counters on exit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_we_d    = op_we_q;
    idx_d      = idx_q;
    data_d     = data_q;
    mout_d     = mout_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    resp_go    = 1'b0;
    ram_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mreq) begin
          op_we_d = mwrite_en;
          idx_d   = maddr[ADDR_WIDTH+1:2];
          data_d  = mdata;
          if (LATENCY == 1) begin
            state_d = S_RESP;
            resp_go = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          resp_go = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (op_we_q) wr_count_d = wr_count_q + 32'd1;
        else         rd_count_d = rd_count_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // With LATENCY==1 the RESP entry edge is the accept edge itself, so the
    // access must use the live inputs instead of the (not yet loaded) latches.
    if (state_q == S_IDLE) begin
      acc_we   = mwrite_en;
      acc_idx  = maddr[ADDR_WIDTH+1:2];
      acc_data = mdata;
    end else begin
      acc_we   = op_we_q;
      acc_idx  = idx_q;
      acc_data = data_q;
    end

    if (resp_go) begin
      ram_we = acc_we;
      mout_d = acc_we ? acc_data : mem_q[acc_idx];
    end
  end

  // Control and status registers; reset discards any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_we_q    <= 1'b0;
      idx_q      <= '0;
      data_q     <= 32'd0;
      mout_q     <= 32'd0;
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_we_q    <= op_we_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      mout_q     <= mout_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Backing RAM: never cleared, and a write racing reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) mem_q[acc_idx] <= acc_data;
  end

  assign mbusy     = (state_q != S_IDLE);
  assign mvalid    = (state_q == S_RESP);
  assign mout      = mout_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: directed scenarios plus randomized traffic
// checked against a word-array model of the RAM and transaction counters.
`timescale 1ns/1ps
module tb_cache_mem_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT with LATENCY=2
  logic        mreq, mwrite_en;
  logic [31:0] maddr, mdata;
  logic        mbusy, mvalid;
  logic [31:0] mout, rd_count, wr_count;
  logic [1:0]  dbg_state;

  // DUT with LATENCY=1
  logic        mreq1, mwrite_en1;
  logic [31:0] maddr1, mdata1;
  logic        mbusy1, mvalid1;
  logic [31:0] mout1, rd_count1, wr_count1;
  logic [1:0]  dbg_state1;

  cache_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mreq(mreq), .mwrite_en(mwrite_en),
    .maddr(maddr), .mdata(mdata), .mbusy(mbusy), .mvalid(mvalid),
    .mout(mout), .rd_count(rd_count), .wr_count(wr_count),
    .dbg_state(dbg_state)
  );

  cache_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mreq(mreq1), .mwrite_en(mwrite_en1),
    .maddr(maddr1), .mdata(mdata1), .mbusy(mbusy1), .mvalid(mvalid1),
    .mout(mout1), .rd_count(rd_count1), .wr_count(wr_count1),
    .dbg_state(dbg_state1)
  );

  // ---------------- reference model ----------------
  logic [31:0] mem_m   [0:(1<<AW)-1];
  bit          valid_m [0:(1<<AW)-1];
  int unsigned exp_rd, exp_wr;
  int          checks, errors;
  logic [31:0] exp_q[$];

  function automatic int word_idx(input logic [31:0] addr);
    return int'((addr >> 2) % (1 << AW));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; mreq = 1'b0; mreq1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0;
  endtask

  // Issue one request on the LATENCY=2 DUT; inputs are scrambled while the
  // request is in flight. Returns mout seen with mvalid and cycles from accept.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] got,
                        output int lat);
    @(negedge clk);
    mreq = 1'b1; mwrite_en = we; maddr = addr; mdata = data;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!mvalid) begin
        maddr = $urandom; mdata = $urandom; mwrite_en = 1'($urandom);
      end
    end while (!mvalid && lat < 40);
    got = mout;
    mreq = 1'b0; mwrite_en = 1'b0;
    checks++;
    if (!mvalid) begin
      errors++;
      $display("FAIL req_timeout: no mvalid after %0d cycles, required within %0d", lat, LAT);
    end else if (we) begin
      mem_m[word_idx(addr)] = data; valid_m[word_idx(addr)] = 1'b1; exp_wr++;
    end else begin
      exp_rd++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (mbusy !== 1'b0) begin errors++; $display("FAIL reset_mbusy: got %0b want 0", mbusy); end
    checks++; if (mvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %0b want 0", mvalid); end
    checks++; if (mout !== 32'd0) begin errors++; $display("FAIL reset_mout: got %h want 0", mout); end
    checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
    checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({mbusy, mvalid, mout, rd_count, wr_count} !== 98'd0) begin
        errors++;
        $display("FAIL idle_hold: cycle %0d busy=%0b valid=%0b mout=%h rd=%0d wr=%0d want all 0",
                 i, mbusy, mvalid, mout, rd_count, wr_count);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] got; int lat;
    do_req(1'b1, 32'h40, 32'hDEADBEEF, got, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
    checks++; if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_echo: got %h want deadbeef", got); end
    do_req(1'b0, 32'h40, 32'h0, got, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT); end
    checks++; if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", got); end
    @(negedge clk);
    checks++; if (wr_count !== 32'd1) begin errors++; $display("FAIL wr_count_1: got %0d want 1", wr_count); end
    checks++; if (rd_count !== 32'd1) begin errors++; $display("FAIL rd_count_1: got %0d want 1", rd_count); end
    checks++; if (mout !== 32'hDEADBEEF) begin errors++; $display("FAIL mout_hold: got %h want deadbeef", mout); end
  endtask

  task automatic test_alias();
    logic [31:0] got; int lat;
    do_req(1'b1, 32'h1004, 32'h11, got, lat);
    do_req(1'b0, 32'h0006, 32'h0, got, lat);
    checks++; if (got !== 32'h11) begin errors++; $display("FAIL alias_read: got %h want 00000011", got); end
  endtask

  // mreq held for 12 cycles alternating between two read addresses.
  task automatic test_back_to_back();
    int pulses, last, cyc;
    logic [31:0] addrs [2];
    int sel;
    logic prev;
    addrs[0] = 32'h40; addrs[1] = 32'h1004; sel = 0;
    exp_q.delete();
    pulses = 0; last = -1; prev = 1'b0;
    @(negedge clk);
    mreq = 1'b1; mwrite_en = 1'b0; maddr = addrs[0];
    exp_q.push_back(mem_m[word_idx(addrs[0])]);
    for (cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (mvalid) begin
        pulses++;
        checks++;
        if (prev) begin errors++; $display("FAIL b2b_width: mvalid high two cycles in a row at cycle %0d", cyc); end
        if (last >= 0) begin
          checks++;
          if (cyc - last != LAT + 1) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - last, LAT + 1); end
        end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra: unexpected pulse at cycle %0d", cyc); end
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (mout !== e) begin errors++; $display("FAIL b2b_data: got %h want %h", mout, e); end
        end
        last = cyc;
        sel = 1 - sel;
        maddr = addrs[sel];
        exp_q.push_back(mem_m[word_idx(addrs[sel])]);
        exp_rd++;
      end
      prev = mvalid;
    end
    mreq = 1'b0;
    checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
    repeat (3) @(negedge clk);
    checks++; if (rd_count !== 32'(exp_rd)) begin errors++; $display("FAIL b2b_rd_count: got %0d want %0d", rd_count, exp_rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got; int lat;
    do_req(1'b1, 32'h8, 32'h77, got, lat);
    apply_reset();
    @(negedge clk);
    mreq = 1'b1; mwrite_en = 1'b1; maddr = 32'h8; mdata = 32'h55;
    @(negedge clk);
    checks++; if (mbusy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b want 1", mbusy); end
    reset = 1'b1; mreq = 1'b0; mwrite_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (mbusy !== 1'b0 || mvalid !== 1'b0) begin errors++; $display("FAIL mid_abort: busy=%0b valid=%0b want 0 0", mbusy, mvalid); end
    do_req(1'b0, 32'h8, 32'h0, got, lat);
    checks++; if (got !== 32'h77) begin errors++; $display("FAIL mid_read: got %h want 00000077", got); end
    @(negedge clk);
    checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL mid_wr_count: got %0d want 0", wr_count); end
    checks++; if (rd_count !== 32'd1) begin errors++; $display("FAIL mid_rd_count: got %0d want 1", rd_count); end
  endtask

  task automatic test_random();
    logic [31:0] got, addr, data, e; int lat; logic we; bit chk;
    for (int n = 0; n < 40; n++) begin
      addr = ($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3)) | ($urandom_range(0, 3) << 12);
      data = $urandom;
      we   = 1'($urandom_range(0, 1));
      chk  = we || valid_m[word_idx(addr)];
      e    = we ? data : mem_m[word_idx(addr)];
      do_req(we, addr, data, got, lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL rnd_latency: op %0d got %0d want %0d", n, lat, LAT); end
      if (chk) begin
        checks++;
        if (got !== e) begin errors++; $display("FAIL rnd_data: op %0d we=%0b addr=%h got %h want %h", n, we, addr, got, e); end
      end
    end
    @(negedge clk);
    checks++; if (rd_count !== 32'(exp_rd)) begin errors++; $display("FAIL rnd_rd_count: got %0d want %0d", rd_count, exp_rd); end
    checks++; if (wr_count !== 32'(exp_wr)) begin errors++; $display("FAIL rnd_wr_count: got %0d want %0d", wr_count, exp_wr); end
  endtask

  task automatic test_latency1();
    logic [31:0] d;
    d = $urandom;
    // write on the accept edge, then read back
    @(negedge clk);
    mreq1 = 1'b1; mwrite_en1 = 1'b1; maddr1 = 32'h10; mdata1 = d;
    @(negedge clk);
    mreq1 = 1'b0; mwrite_en1 = 1'b0;
    checks++; if (mvalid1 !== 1'b1 || mout1 !== d) begin errors++; $display("FAIL l1_write: valid=%0b mout=%h want 1 %h", mvalid1, mout1, d); end
    @(negedge clk);
    mreq1 = 1'b1; maddr1 = 32'h12;
    @(negedge clk);
    mreq1 = 1'b0;
    checks++; if (mvalid1 !== 1'b1) begin errors++; $display("FAIL l1_read_valid: got %0b want 1", mvalid1); end
    checks++; if (mout1 !== d) begin errors++; $display("FAIL l1_read_data: got %h want %h", mout1, d); end
    @(negedge clk);
    checks++; if (mbusy1 !== 1'b0 || mvalid1 !== 1'b0) begin errors++; $display("FAIL l1_idle: busy=%0b valid=%0b want 0 0", mbusy1, mvalid1); end
    checks++; if (rd_count1 !== 32'd1 || wr_count1 !== 32'd1) begin errors++; $display("FAIL l1_counts: rd=%0d wr=%0d want 1 1", rd_count1, wr_count1); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    mreq = 1'b0; mwrite_en = 1'b0; maddr = 32'd0; mdata = 32'd0;
    mreq1 = 1'b0; mwrite_en1 = 1'b0; maddr1 = 32'd0; mdata1 = 32'd0;
    for (int i = 0; i < (1 << AW); i++) begin mem_m[i] = 32'd0; valid_m[i] = 1'b0; end
    exp_rd = 0; exp_wr = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    test_random();
    apply_reset();
    test_latency1();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
